// File: rtl/edge_pulse_bank.sv
// Multi-channel edge-to-pulse converter: synchroniser, debounce filter,
// selectable edge detect and pulse stretcher per channel.
module edge_pulse_bank #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] din,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pulse,
    output logic                any_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] P_LOAD  = PW'(PULSE_LEN);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DW-1:0] cnt_q, cnt_d;
        logic [PW-1:0] pcnt_q, pcnt_d;
        logic          lvl_q, lvl_d;
        logic          accept;
        logic          fire;

        always_comb begin
            cnt_d  = '0;
            lvl_d  = lvl_q;
            accept = 1'b0;
            if (s[c] != lvl_q) begin
                if (cnt_q == DB_LAST) begin
                    lvl_d  = s[c];
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
        end

        // mode only matters on the accept edge; in-flight pulses ignore it
        always_comb begin
            fire = 1'b0;
            if (accept) begin
                unique case (mode)
                    2'b00:   fire = lvl_d;
                    2'b01:   fire = ~lvl_d;
                    2'b10:   fire = 1'b1;
                    default: fire = 1'b0;
                endcase
            end
        end

        always_comb begin
            pcnt_d = pcnt_q;
            if (fire) begin
                pcnt_d = P_LOAD;
            end else if (pcnt_q != '0) begin
                pcnt_d = pcnt_q - PW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                lvl_q  <= 1'b0;
                pcnt_q <= '0;
            end else begin
                cnt_q  <= cnt_d;
                lvl_q  <= lvl_d;
                pcnt_q <= pcnt_d;
            end
        end

        assign level[c] = lvl_q;
        assign pulse[c] = (pcnt_q != '0);
    end

    assign any_pulse = |pulse;

endmodule
